// File: rtl/ber_test_ctrl.sv
// ber_test_ctrl
//   Bit-error-rate test controller. A test is armed with a word count; every
//   valid tx/rx word pair seen while running is compared bitwise and the
//   mismatching bits are accumulated. The test ends when the requested number
//   of words has been compared, or early on abort. All counters saturate at
//   their all-ones value.
//
//   State table
//     IDLE | no test since reset, waiting for start
//     RUN  | test in progress, accumulating valid words
//     DONE | test finished, counters frozen until the next accepted start
//
//   Ports
//     clk, rst             clock, asynchronous active-high reset
//     start, word_count    begin a test of word_count words (ignored if 0 or busy)
//     abort                end a running test early
//     word_valid           tx_word/rx_word pair valid this cycle
//     tx_word, rx_word     transmitted / received pattern words (W bits)
//     busy, done, aborted  status flags
//     words_done           words compared in the current/last test
//     bits_total           words_done * W
//     err_total            accumulated bit errors, err_sat once saturated
//     err_words            words with at least one bit error
module ber_test_ctrl #(
  parameter int W  = 13,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] word_count,
  input  logic          word_valid,
  input  logic [W-1:0]  tx_word,
  input  logic [W-1:0]  rx_word,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [CW-1:0] words_done,
  output logic [CW-1:0] bits_total,
  output logic [CW-1:0] err_total,
  output logic [CW-1:0] err_words,
  output logic          err_sat
);

  localparam int PW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] target;

  logic [W-1:0]  diff;
  logic [PW-1:0] word_errs;
  logic [CW:0]   err_sum;
  logic [CW:0]   bits_sum;
  logic [CW-1:0] err_next;
  logic [CW-1:0] bits_next;
  logic [CW-1:0] words_next;
  logic [CW-1:0] errw_next;
  logic          sat_next;

  assign diff = tx_word ^ rx_word;

  always_comb begin
    word_errs = '0;
    for (int i = 0; i < W; i++) begin
      word_errs = word_errs + PW'(diff[i]);
    end
  end

  // One extra bit on the adders exposes the carry used for saturation.
  always_comb begin
    err_sum    = {1'b0, err_total} + (CW+1)'(word_errs);
    bits_sum   = {1'b0, bits_total} + (CW+1)'(W);
    err_next   = err_sum[CW] ? CNT_MAX : err_sum[CW-1:0];
    bits_next  = bits_sum[CW] ? CNT_MAX : bits_sum[CW-1:0];
    words_next = (words_done == CNT_MAX) ? CNT_MAX : words_done + 1'b1;
    errw_next  = (word_errs == '0 || err_words == CNT_MAX) ? err_words : err_words + 1'b1;
    // err_sat tracks err_total having reached the ceiling; it is sticky
    // because err_total never decreases within a test.
    sat_next   = err_sat | (err_next == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      words_done <= '0;
      bits_total <= '0;
      err_total  <= '0;
      err_words  <= '0;
      err_sat    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && word_count != '0) begin
            state      <= RUN;
            target     <= word_count;
            busy       <= 1'b1;
            done       <= 1'b0;
            aborted    <= 1'b0;
            words_done <= '0;
            bits_total <= '0;
            err_total  <= '0;
            err_words  <= '0;
            err_sat    <= 1'b0;
          end
        end
        RUN: begin
          if (word_valid) begin
            words_done <= words_next;
            bits_total <= bits_next;
            err_total  <= err_next;
            err_words  <= errw_next;
            err_sat    <= sat_next;
          end
          // Completion wins over a coincident abort.
          if (word_valid && words_next == target) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (abort) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ber_test_ctrl.sv
module tb_ber_test_ctrl;

  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, word_valid;
  logic [31:0] word_count;
  logic [W-1:0] tx_word, rx_word;

  logic        busy, done, aborted, err_sat;
  logic [31:0] words_done, bits_total, err_total, err_words;

  logic        busy8, done8, aborted8, err_sat8;
  logic [7:0]  words_done8, bits_total8, err_total8, err_words8;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural reference: unbounded counts, clipped to each width on compare.
  bit     m_run, m_done, m_abt;
  longint m_target, m_words, m_err, m_errw;

  always #5 clk = ~clk;

  ber_test_ctrl #(.W(W), .CW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .word_count(word_count), .word_valid(word_valid),
    .tx_word(tx_word), .rx_word(rx_word),
    .busy(busy), .done(done), .aborted(aborted),
    .words_done(words_done), .bits_total(bits_total),
    .err_total(err_total), .err_words(err_words), .err_sat(err_sat)
  );

  ber_test_ctrl #(.W(W), .CW(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .word_count(word_count[7:0]), .word_valid(word_valid),
    .tx_word(tx_word), .rx_word(rx_word),
    .busy(busy8), .done(done8), .aborted(aborted8),
    .words_done(words_done8), .bits_total(bits_total8),
    .err_total(err_total8), .err_words(err_words8), .err_sat(err_sat8)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint clip(input longint v, input int cw);
    longint m;
    m = (longint'(1) << cw) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_abt = 0;
    m_target = 0; m_words = 0; m_err = 0; m_errw = 0;
  endfunction

  function automatic void model_edge();
    int pe;
    if (!m_run) begin
      if (start && word_count != 0) begin
        m_run = 1; m_done = 0; m_abt = 0;
        m_target = word_count;
        m_words = 0; m_err = 0; m_errw = 0;
      end
    end else begin
      if (word_valid) begin
        pe = $countones(tx_word ^ rx_word);
        m_words++;
        m_err += pe;
        if (pe != 0) m_errw++;
      end
      if (word_valid && m_words == m_target) begin
        m_run = 0; m_done = 1; m_abt = 0;
      end else if (abort) begin
        m_run = 0; m_done = 1; m_abt = 1;
      end
    end
  endfunction

  task automatic compare_all();
    chk("busy",       busy,       m_run);
    chk("done",       done,       m_done);
    chk("aborted",    aborted,    m_abt);
    chk("words_done", words_done, clip(m_words, 32));
    chk("bits_total", bits_total, clip(m_words * W, 32));
    chk("err_total",  err_total,  clip(m_err, 32));
    chk("err_words",  err_words,  clip(m_errw, 32));
    chk("err_sat",    err_sat,    m_err >= clip(m_err + 64'hFFFF_FFFF, 32));
    chk("busy8",       busy8,       m_run);
    chk("done8",       done8,       m_done);
    chk("aborted8",    aborted8,    m_abt);
    chk("words_done8", words_done8, clip(m_words, 8));
    chk("bits_total8", bits_total8, clip(m_words * W, 8));
    chk("err_total8",  err_total8,  clip(m_err, 8));
    chk("err_words8",  err_words8,  clip(m_errw, 8));
    chk("err_sat8",    err_sat8,    m_err >= 255);
  endtask

  // Called just after a falling edge: drive, advance model, clock, compare.
  task automatic step(input logic s, input logic a, input logic v,
                      input logic [W-1:0] t, input logic [W-1:0] r,
                      input logic [31:0] wc);
    start = s; abort = a; word_valid = v;
    tx_word = t; rx_word = r; word_count = wc;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic word(input logic [W-1:0] err_pat, input logic a);
    logic [W-1:0] t;
    t = W'($urandom);
    step(1'b0, a, 1'b1, t, t ^ err_pat, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_abt"},   aborted, 0);
    chk({tag, "_words"}, words_done, 0);
    chk({tag, "_bits"},  bits_total, 0);
    chk({tag, "_err"},   err_total, 0);
    chk({tag, "_errw"},  err_words, 0);
    chk({tag, "_sat"},   err_sat, 0);
    chk({tag, "_busy8"}, busy8, 0);
    chk({tag, "_err8"},  err_total8, 0);
    chk({tag, "_sat8"},  err_sat8, 0);
  endtask

  initial begin
    logic [W-1:0] pat, t;
    int           r;
    rst = 1'b1; start = 0; abort = 0; word_valid = 0;
    word_count = 0; tx_word = 0; rx_word = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Idle noise: valid words and abort without a start do nothing.
    step(0, 1, 1, 13'h0AAA, 13'h0555, 32'd9);
    chk("idle_words", words_done, 0);

    // Four clean words.
    step(1, 0, 0, 0, 0, 32'd4);
    chk("run_busy", busy, 1);
    for (int i = 0; i < 4; i++) word(13'h0000, 1'b0);
    chk("clean_done", done, 1);
    chk("clean_words", words_done, 4);
    chk("clean_bits", bits_total, 52);
    chk("clean_err", err_total, 0);
    chk("clean_errw", err_words, 0);
    chk("clean_abt", aborted, 0);

    // Mixed error patterns.
    step(1, 0, 0, 0, 0, 32'd3);
    word(13'h0001, 1'b0);
    word(13'h1FFF, 1'b0);
    word(13'h0000, 1'b0);
    chk("mix_err", err_total, 14);
    chk("mix_errw", err_words, 2);
    chk("mix_bits", bits_total, 39);
    chk("mix_done", done, 1);

    // Abort after five words, with and without a word in the abort cycle.
    step(1, 0, 0, 0, 0, 32'd10);
    for (int i = 0; i < 5; i++) word(13'h0010, 1'b0);
    step(0, 1, 0, 0, 0, 0);
    chk("abt_done", done, 1);
    chk("abt_flag", aborted, 1);
    chk("abt_words", words_done, 5);
    step(1, 0, 0, 0, 0, 32'd10);
    chk("start_clears_abt", aborted, 0);
    for (int i = 0; i < 5; i++) word(13'h0000, 1'b0);
    word(13'h0003, 1'b1);
    chk("abtv_flag", aborted, 1);
    chk("abtv_words", words_done, 6);
    chk("abtv_err", err_total, 2);

    // Zero-length start is ignored; DONE holds its counters.
    step(1, 0, 0, 0, 0, 32'd0);
    chk("zero_busy", busy, 0);
    chk("zero_hold", words_done, 6);

    // Start during RUN does not clear.
    step(1, 0, 0, 0, 0, 32'd5);
    word(13'h0000, 1'b0);
    t = W'($urandom);
    step(1, 0, 1, t, t, 32'd7);
    chk("restart_ignored", words_done, 2);
    for (int i = 0; i < 3; i++) word(13'h0000, 1'b0);
    chk("restart_target", done, 1);

    // Abort coincident with final word: completion wins.
    step(1, 0, 0, 0, 0, 32'd2);
    word(13'h0000, 1'b0);
    word(13'h0001, 1'b1);
    chk("last_abt", aborted, 0);
    chk("last_words", words_done, 2);

    // Saturation on the 8-bit instance: 25 words x 13 errors.
    step(1, 0, 0, 0, 0, 32'd25);
    for (int i = 0; i < 25; i++) word(13'h1FFF, 1'b0);
    chk("sat_err8", err_total8, 255);
    chk("sat_flag8", err_sat8, 1);
    chk("sat_bits8", bits_total8, 255);
    chk("sat_err32", err_total, 325);
    chk("sat_flag32", err_sat, 0);

    // Asynchronous reset mid-run.
    step(1, 0, 0, 0, 0, 32'd50);
    for (int i = 0; i < 3; i++) word(13'h0101, 1'b0);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 13'h0F0F, 13'h0000, 32'd8);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       pat = '0;
        1:       pat = '0;
        2:       pat = W'(1) << $urandom_range(0, W - 1);
        default: pat = W'($urandom);
      endcase
      t = W'($urandom);
      if (!m_run) begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 1) == 0, t, t ^ pat,
             ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 40)));
      end else begin
        step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 9) < 7, t, t ^ pat,
             32'($urandom_range(0, 40)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
